datapath_seq_ctrl: RTL and testbench
====================================

// Module: datapath_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 16-bit datapath (IR, register file, ALU, unified memory).
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the regfile write strobe,
//  ALU op, memory handshake and PC controls. Purely control: holds no data registers.
//  ISA fields: opcode[15:12], rd/op1[11:8], op2[7:4], funct[3:0].
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ack before raising bus_err and halting (0 = no timeout)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   reset, asynchronous, active-low
//  instr       in   16  current IR contents
//  mem_ack     in   1   memory completes the access this cycle (read data valid)
//  alu_zero    in   1   ALU result == 0 (compare in EXEC)
//  alu_neg     in   1   ALU result bit 15
//  ir_load     out  1   IR captures memory read data
//  pc_inc      out  1   PC <= PC + 2
//  pc_load     out  1   PC <= branch/jump target
//  reg_write   out  1   regfile write enable (one cycle)
//  reg_wsel    out  1   0: write rd = instr[11:8]; 1: write R15
//  wb_src      out  2   00 ALU result, 01 memory data, 10 ALU upper/remainder
//  alu_op      out  4   ALU function (funct for type A; ADD for address; SUB for compare)
//  mem_req     out  1   memory request, held until mem_ack
//  mem_we      out  1   write access (valid with mem_req)
//  halted      out  1   sequencer in HALT
//  bus_err     out  1   sticky: memory timeout occurred
//  illegal_op  out  1   sticky: undefined opcode decoded
// BEHAVIOUR
//  Reset (reset low, async): state=FETCH; all outputs 0; sticky flags cleared.
//  Opcodes: 1111 type A ALU; 1000 LW; 1011 SW; 0110 BEQ; 0100 BLT; 1100 JMP; 0000 HALT; others illegal.
//  Outputs are Moore decodes of state + instr; no output depends combinationally on mem_ack except ir_load/pc_inc.
//  FETCH: mem_req=1, mem_we=0. On mem_ack: ir_load=1, pc_inc=1 same cycle, -> DECODE.
//  DECODE: one cycle, no strobes. Illegal -> set illegal_op, -> HALT. 0000 -> HALT.
//  EXEC: type A: alu_op=funct -> WB. LW/SW: alu_op=ADD (address) -> MEM.
//    BEQ: alu_op=SUB; pc_load=1 if alu_zero. BLT: pc_load=1 if alu_neg. JMP: pc_load=1. Branches -> FETCH.
//  MEM: mem_req=1, mem_we=(SW). Hold until mem_ack. SW -> FETCH; LW -> WB.
//  WB: reg_write=1, reg_wsel=0, wb_src=00 (type A) or 01 (LW) -> FETCH (or WB_R15, see CONFIGURATION).
//  HALT: terminal; halted=1; only reset exits.
//  Latency (zero-wait memory, mem_ack in first request cycle): type A 4, LW 5, SW 4, branch/JMP 3 cycles.
//  Wait states: mem_req stays high, state unchanged, no other strobes while waiting.
//  Timeout: MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT in FETCH/MEM without ack -> bus_err=1, -> HALT.
//    Counter clears on entry to each FETCH/MEM and on ack. Ack on the timeout cycle wins (no error).
//  Writes to rd=0: issued normally; regfile ignores them.
//  Reset mid-access: mem_req drops immediately (async); no partial reg_write is ever produced.
//  reg_write is never high in the same cycle as mem_req.
// CONFIGURATION
//  MULDIV_R15_EN defined: type A funct 0100 (MUL) and 0101 (DIV) go WB -> WB_R15: second cycle
//    reg_write=1, reg_wsel=1, wb_src=10 (product high / remainder into R15); adds 1 cycle (5 total).
//  Not defined: MUL/DIV take the plain WB path; R15 untouched; reg_wsel tied 0; wb_src never 10.
// STRUCTURE
//  Shared package datapath_pkg: opcode and funct localparams, state encoding (3-bit), wb_src codes.
//  Sub-module instr_class_decode (combinational): instr -> {is_alu, is_lw, is_sw, is_br, is_jmp,
//    is_halt, is_illegal, is_muldiv}; reused by the hazard/debug logic.
//  Top holds FSM, timeout counter, sticky flags.
// TESTING
//  ADD 0xF120 with mem_ack on 1st FETCH cycle -> ir_load+pc_inc c1, reg_write c4 only, wb_src=00, rd=1.
//  LW 0x8310, ack delayed 3 cycles in MEM -> mem_req high 4 cycles, reg_write 1 cycle after ack, wb_src=01.
//  BEQ 0x6120, alu_zero=1 -> pc_load in EXEC, no reg_write; alu_zero=0 -> no pc_load.
//  MUL 0xF344 with MULDIV_R15_EN -> reg_write 2 consecutive cycles, reg_wsel 0 then 1; without -> 1 cycle.
//  No mem_ack for MEM_TIMEOUT cycles in FETCH -> bus_err=1, halted=1; opcode 0x2xxx -> illegal_op, halted.
//  reset pulled low mid-MEM wait -> all outputs 0 immediately; after release, FETCH with mem_req=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the 16-bit datapath sequencer: opcodes, funct codes,
// ALU ops, FSM state encoding and write-back source selects.
package datapath_pkg;

  localparam logic [3:0] OP_ALU  = 4'b1111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b0000;

  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_WB_R15 = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_HI  = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic is_alu;
    logic is_lw;
    logic is_sw;
    logic is_br;
    logic is_jmp;
    logic is_halt;
    logic is_illegal;
    logic is_muldiv;
  } instr_class_t;

endpackage

// File: rtl/datapath_seq_ctrl_instr_class_decode.sv
// Combinational instruction classifier; shared by the sequencer and the
// hazard/debug logic. Only opcode and funct matter for classification.
module instr_class_decode
  import datapath_pkg::*;
(
  input  logic [15:0]  instr_i,
  output instr_class_t cls_o
);

  logic [3:0] op;
  logic [3:0] fn;
  logic       unused_fields;

  assign op = instr_i[15:12];
  assign fn = instr_i[3:0];
  assign unused_fields = ^instr_i[11:4];

  always_comb begin
    cls_o = '0;
    case (op)
      OP_ALU: begin
        cls_o.is_alu    = 1'b1;
        cls_o.is_muldiv = (fn == FN_MUL) || (fn == FN_DIV);
      end
      OP_LW:          cls_o.is_lw   = 1'b1;
      OP_SW:          cls_o.is_sw   = 1'b1;
      OP_BEQ, OP_BLT: cls_o.is_br   = 1'b1;
      OP_JMP:         cls_o.is_jmp  = 1'b1;
      OP_HALT:        cls_o.is_halt = 1'b1;
      default:        cls_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit datapath.
// Define MULDIV_R15_EN to add the second write-back cycle (R15) for MUL/DIV.
//
// state   | meaning
// FETCH   | instruction read from memory, waits for mem_ack
// DECODE  | one idle cycle while the IR is classified
// EXEC    | ALU op / address calc / branch resolve
// MEM     | data access for LW/SW, waits for mem_ack
// WB      | regfile write of rd
// WB_R15  | second write of MUL/DIV upper half or remainder into R15
// HALT    | terminal, only reset exits
module datapath_seq_ctrl
  import datapath_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_write,
  output logic        reg_wsel,
  output logic [1:0]  wb_src,
  output logic [3:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal_op
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LOAD = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  logic          waiting;
  logic          timeout;
  instr_class_t  cls;
  logic          unused_muldiv;

  instr_class_decode u_decode (
    .instr_i (instr),
    .cls_o   (cls)
  );

  assign unused_muldiv = cls.is_muldiv;

  // Down-counter reloads whenever not stalled on memory; terminal count with no ack is the timeout.
  assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt_q == '0);
  assign cnt_d   = waiting ? (cnt_q - CW'(1)) : TO_LOAD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      cnt_q     <= TO_LOAD;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (cls.is_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (cls.is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls.is_alu)                  state_d = ST_WB;
        else if (cls.is_lw || cls.is_sw) state_d = ST_MEM;
        else                             state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = cls.is_lw ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
`ifdef MULDIV_R15_EN
        state_d = (cls.is_alu && cls.is_muldiv) ? ST_WB_R15 : ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_WB_R15: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Gated by reset so an in-flight mem_req drops the moment reset asserts.
  always_comb begin
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_write = 1'b0;
    reg_wsel  = 1'b0;
    wb_src    = WB_ALU;
    alu_op    = ALU_ADD;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ack;
          pc_inc  = mem_ack;
        end
        ST_EXEC: begin
          if (cls.is_alu) begin
            alu_op = instr[3:0];
          end else if (cls.is_br) begin
            alu_op  = ALU_SUB;
            pc_load = (instr[15:12] == OP_BEQ) ? alu_zero : alu_neg;
          end else begin
            alu_op  = ALU_ADD;
            pc_load = cls.is_jmp;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = cls.is_sw;
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_src    = cls.is_lw ? WB_MEM : WB_ALU;
        end
        ST_WB_R15: begin
`ifdef MULDIV_R15_EN
          reg_write = 1'b1;
          reg_wsel  = 1'b1;
          wb_src    = WB_HI;
`endif
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_err    = bus_err_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Self-checking bench for datapath_seq_ctrl: directed vector table, random
// instruction stream against a per-instruction cycle-trace model, and corner sequences.
module tb_datapath_seq_ctrl;
  import datapath_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        mem_ack = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0;
  logic        ir_load, pc_inc, pc_load, reg_write, reg_wsel, mem_req, mem_we;
  logic        halted, bus_err, illegal_op;
  logic [1:0]  wb_src;
  logic [3:0]  alu_op;
  logic [15:0] obs;

  datapath_seq_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ack(mem_ack),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .reg_write(reg_write), .reg_wsel(reg_wsel), .wb_src(wb_src),
    .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .bus_err(bus_err), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {ir_load, pc_inc, pc_load, reg_write, reg_wsel, wb_src, alu_op,
                mem_req, mem_we, halted, illegal_op, bus_err};

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit          ack;
    logic [15:0] exp;
  } step_t;
  step_t tr[$];

  typedef struct {
    logic [15:0] ins;
    int          fd, md;
    bit          z, n;
    int          rw, pcl;
    logic [1:0]  wb;
    bit          hlt;
  } vec_t;
  vec_t tbl[$];

`ifdef MULDIV_R15_EN
  localparam int MD_RW = 2;
  localparam logic [1:0] MD_WB = 2'd2;
`else
  localparam int MD_RW = 1;
  localparam logic [1:0] MD_WB = 2'd0;
`endif

  function automatic logic [15:0] ev(bit irl, bit pci, bit pcl, bit rw, bit ws,
                                     logic [1:0] wb, logic [3:0] alu, bit rq, bit we,
                                     bit h, bit il, bit be);
    return {irl, pci, pcl, rw, ws, wb, alu, rq, we, h, il, be};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, straight from the phase rules.
  task automatic build(input logic [15:0] ins, input int fd, input int md, input bit z, input bit n);
    logic [3:0] op, fn, alu;
    bit legal, pcl;
    op = ins[15:12];
    fn = ins[3:0];
    tr.delete();
    instr = ins;
    alu_zero = z;
    alu_neg = n;
    legal = op inside {4'hF, 4'h8, 4'hB, 4'h6, 4'h4, 4'hC, 4'h0};
    repeat (fd) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,1,0,0,0,0)});
    tr.push_back('{1'b1, ev(1,1,0,0,0,2'd0,4'd0,1,0,0,0,0)});
    tr.push_back('{1'b0, 16'h0});
    if (!legal || op == 4'h0) begin
      repeat (3) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,0,0,1,!legal,0)});
      return;
    end
    pcl = 1'b0;
    case (op)
      4'hF: alu = fn;
      4'h6: begin alu = ALU_SUB; pcl = z; end
      4'h4: begin alu = ALU_SUB; pcl = n; end
      4'hC: begin alu = ALU_ADD; pcl = 1'b1; end
      default: alu = ALU_ADD;
    endcase
    tr.push_back('{1'b0, ev(0,0,pcl,0,0,2'd0,alu,0,0,0,0,0)});
    if (op == 4'h8 || op == 4'hB) begin
      repeat (md) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,1,op == 4'hB,0,0,0)});
      tr.push_back('{1'b1, ev(0,0,0,0,0,2'd0,4'd0,1,op == 4'hB,0,0,0)});
    end
    if (op == 4'hF || op == 4'h8)
      tr.push_back('{1'b0, ev(0,0,0,1,0,(op == 4'h8) ? 2'd1 : 2'd0,4'd0,0,0,0,0,0)});
`ifdef MULDIV_R15_EN
    if (op == 4'hF && (fn == 4'h4 || fn == 4'h5))
      tr.push_back('{1'b0, ev(0,0,0,1,1,2'd2,4'd0,0,0,0,0,0)});
`endif
  endtask

  // Entered and left at posedge+1; outputs sampled at the falling edge.
  task automatic run_trace(output int rw_cnt, output int pcl_cnt, output logic [1:0] wb_seen,
                           output bit hlt);
    rw_cnt = 0;
    pcl_cnt = 0;
    wb_seen = 2'd0;
    hlt = 1'b0;
    foreach (tr[i]) begin
      mem_ack = tr[i].ack;
      @(negedge clk);
      check($sformatf("cyc%0d_ins%h", i, instr), obs, tr[i].exp);
      if (reg_write) begin
        rw_cnt++;
        wb_seen = wb_src;
      end
      if (pc_load) pcl_cnt++;
      hlt = halted;
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    mem_ack = 1'b0;
    #2;
    check("reset_outputs", obs, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int rw, pcl;
    logic [1:0] wbs;
    bit hlt;
    logic [3:0] ops[7];

    tbl.push_back('{16'hF120, 0, 0, 0, 0, 1, 0, 2'd0, 0});
    tbl.push_back('{16'h8310, 0, 3, 0, 0, 1, 0, 2'd1, 0});
    tbl.push_back('{16'hB210, 0, 0, 0, 0, 0, 0, 2'd0, 0});
    tbl.push_back('{16'h6120, 0, 0, 1, 0, 0, 1, 2'd0, 0});
    tbl.push_back('{16'h6120, 1, 0, 0, 1, 0, 0, 2'd0, 0});
    tbl.push_back('{16'h4120, 0, 0, 0, 1, 0, 1, 2'd0, 0});
    tbl.push_back('{16'h4120, 0, 0, 1, 0, 0, 0, 2'd0, 0});
    tbl.push_back('{16'hC000, 2, 0, 0, 0, 0, 1, 2'd0, 0});
    tbl.push_back('{16'hF344, 0, 0, 0, 0, MD_RW, 0, MD_WB, 0});
    tbl.push_back('{16'hF355, 1, 0, 0, 0, MD_RW, 0, MD_WB, 0});
    tbl.push_back('{16'hF126, TO - 1, 0, 0, 0, 1, 0, 2'd0, 0});
    tbl.push_back('{16'h8010, 0, TO - 1, 0, 0, 1, 0, 2'd1, 0});
    tbl.push_back('{16'hF012, 0, 0, 0, 0, 1, 0, 2'd0, 0});
    tbl.push_back('{16'h2345, 0, 0, 0, 0, 0, 0, 2'd0, 1});
    tbl.push_back('{16'h0000, 0, 0, 0, 0, 0, 0, 2'd0, 1});
    tbl.push_back('{16'hE001, 0, 0, 0, 0, 0, 0, 2'd0, 1});

    reset_dut();

    foreach (tbl[k]) begin
      build(tbl[k].ins, tbl[k].fd, tbl[k].md, tbl[k].z, tbl[k].n);
      run_trace(rw, pcl, wbs, hlt);
      check($sformatf("tbl%0d_regwrites", k), 16'(rw), 16'(tbl[k].rw));
      check($sformatf("tbl%0d_pcloads", k), 16'(pcl), 16'(tbl[k].pcl));
      check($sformatf("tbl%0d_wbsrc", k), {14'd0, wbs}, {14'd0, tbl[k].wb});
      check($sformatf("tbl%0d_halted", k), {15'd0, hlt}, {15'd0, tbl[k].hlt});
      if (hlt) reset_dut();
    end

    // Fetch timeout straight out of reset.
    tr.delete();
    repeat (TO) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,1,0,0,0,0)});
    repeat (2) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,0,0,1,0,1)});
    run_trace(rw, pcl, wbs, hlt);
    reset_dut();

    // Data-phase timeout on a store.
    instr = 16'hB000;
    tr.delete();
    tr.push_back('{1'b1, ev(1,1,0,0,0,2'd0,4'd0,1,0,0,0,0)});
    tr.push_back('{1'b0, 16'h0});
    tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,ALU_ADD,0,0,0,0,0)});
    repeat (TO) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,1,1,0,0,0)});
    repeat (2) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,0,0,1,0,1)});
    run_trace(rw, pcl, wbs, hlt);
    reset_dut();

    // Reset asserted mid-way through an LW data wait.
    instr = 16'h8310;
    tr.delete();
    tr.push_back('{1'b1, ev(1,1,0,0,0,2'd0,4'd0,1,0,0,0,0)});
    tr.push_back('{1'b0, 16'h0});
    tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,ALU_ADD,0,0,0,0,0)});
    repeat (2) tr.push_back('{1'b0, ev(0,0,0,0,0,2'd0,4'd0,1,0,0,0,0)});
    run_trace(rw, pcl, wbs, hlt);
    #3;
    reset = 1'b0;
    #1;
    check("reset_mid_mem", obs, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("fetch_after_reset", obs, ev(0,0,0,0,0,2'd0,4'd0,1,0,0,0,0));
    @(posedge clk);
    #1;
    reset_dut();

    // Random instruction stream, mostly legal opcodes with occasional long waits.
    ops = '{4'hF, 4'h8, 4'hB, 4'h6, 4'h4, 4'hC, 4'hF};
    for (int r = 0; r < 60; r++) begin
      logic [15:0] ins;
      int fd, md;
      ins = 16'($urandom);
      if ($urandom_range(0, 9) < 8) ins[15:12] = ops[$urandom_range(0, 6)];
      fd = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
      md = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
      build(ins, fd, md, 1'($urandom), 1'($urandom));
      run_trace(rw, pcl, wbs, hlt);
      if (hlt) reset_dut();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
